fp_mul_arbiter: RTL and testbench
=================================

// Module: fp_mul_arbiter
// PURPOSE
// - Shares one floating_point_mul_1 instance (AXI-stream a/b/result, single precision) among N_REQ requesters.
// - Round-robin grant of operand pairs; tags each issue, routes each result back to its originating requester in order.
// - Sits between the distance/score engines and the multiplier on the bus_clk domain.
// PARAMETERS
// - N_REQ      2   number of requesters, 2..4
// - TAG_DEPTH  32  max in-flight products (power of 2), must exceed multiplier latency
// PORTS
// - bus_clk         in   1          clock, all logic rising edge
// - rst             in   1          asynchronous, active-high reset
// - req_valid       in   N_REQ      requester i has an operand pair
// - req_ready       out  N_REQ      pair accepted when req_valid[i]&req_ready[i]
// - req_a_tdata     in   32*N_REQ   operand A, slice i = [32*i+31:32*i]
// - req_b_tdata     in   32*N_REQ   operand B, same slicing
// - rsp_valid       out  N_REQ      product available for requester i
// - rsp_ready       in   N_REQ      requester i accepts product
// - rsp_tdata       out  32         product, shared bus, qualified by rsp_valid
// - mul_a_tvalid/mul_a_tready/mul_a_tdata  out/in/out  1/1/32  to s_axis_a
// - mul_b_tvalid/mul_b_tready/mul_b_tdata  out/in/out  1/1/32  to s_axis_b
// - mul_r_tvalid/mul_r_tready/mul_r_tdata  in/out/in   1/1/32  from m_axis_result
// - busy            out  1          issue register loaded or products in flight
// BEHAVIOUR
// - Reset: req_ready=0, rsp_valid=0, mul_a_tvalid=mul_b_tvalid=0, mul_r_tready=0, busy=0, rr pointer=0, tag FIFO empty, data regs 0.
// - Issue register: holds a_data, b_data, tag; flags a_pend, b_pend. a_pend clears on mul_a_tvalid&mul_a_tready, b_pend on B handshake, independently (A and B may be accepted in different cycles).
// - mul_a_tvalid=a_pend, mul_b_tvalid=b_pend; data stable while pending (AXI rule: valid never drops before handshake).
// - Issue stage free = !a_pend&!b_pend, or both clear this cycle (back-to-back issue allowed).
// - Grant: when free and tag FIFO not full, req_ready one-hot = first req_valid at or after rr pointer (wrapping); combinational from registered state and req_valid. No grant -> req_ready all 0.
// - On grant of i: load a/b slices of i, set a_pend=b_pend=1, push tag i; rr pointer <= i+1 mod N_REQ. Latency: grant cycle n -> mul_*_tvalid high at n+1.
// - Tag push occurs at grant; FIFO full (TAG_DEPTH entries) blocks grants, never results.
// - Return: t = tag FIFO head; mul_r_tready = !empty & rsp_ready[t]; rsp_valid[t] = mul_r_tvalid & !empty; rsp_tdata = mul_r_tdata (pass-through, zero added latency). Pop tag on result handshake.
// - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap mod TAG_DEPTH.
// - mul_r_tvalid with tag FIFO empty: protocol error; mul_r_tready stays 0, result not consumed.
// - Backpressure: stalled rsp_ready[t] stalls all returns (in-order), issue continues until FIFO full.
// - busy = a_pend | b_pend | !tag_empty.
// - Reset mid-operation: all state cleared immediately; in-flight products are orphaned; multiplier must share rst.
// CONFIGURATION
// - FPMUL_ARB_STATS_EN defined: adds outputs stat_issued (32 x N_REQ, per-requester grant counters, wrap at 2^32) and stat_max_inflight (log2(TAG_DEPTH)+1 bits, high-water mark of tag count); both clear on rst.
// - FPMUL_ARB_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
// - Single req0 A=0x40000000 B=0x40400000 -> mul_a/b_tdata same next cycle, rsp_valid[0] with rsp_tdata=0x40C00000.
// - req0,req1 both held valid with 0x3F99999A pairs -> grants alternate 0,1,0,1; each rsp 0x3FB851EC to correct port.
// - mul_b_tready low 3 cycles after A accepted -> b stays valid/stable, no new grant, no tag duplicated.
// - rsp_ready[0]=0 with 40 continuous issues -> exactly TAG_DEPTH=32 grants then req_ready=0; release drains 32 in order.
// - rst asserted while 5 in flight -> all outputs to reset values same edge; busy=0; next grant goes to req0.
// - STATS_EN: 10 grants req0, 6 req1 -> stat_issued=10/6; stat_max_inflight equals peak tag count.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one AXI-stream FP multiplier among N_REQ requesters.
// Optional FPMUL_ARB_STATS_EN adds per-requester grant counters and in-flight high-water mark.
module fp_mul_arbiter #(
   parameter int N_REQ     = 2,
   parameter int TAG_DEPTH = 32
) (
   input  logic                  bus_clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [32*N_REQ-1:0]   req_a_tdata,
   input  logic [32*N_REQ-1:0]   req_b_tdata,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [31:0]           rsp_tdata,
   output logic                  mul_a_tvalid,
   input  logic                  mul_a_tready,
   output logic [31:0]           mul_a_tdata,
   output logic                  mul_b_tvalid,
   input  logic                  mul_b_tready,
   output logic [31:0]           mul_b_tdata,
   input  logic                  mul_r_tvalid,
   output logic                  mul_r_tready,
   input  logic [31:0]           mul_r_tdata,
`ifdef FPMUL_ARB_STATS_EN
   output logic [32*N_REQ-1:0]   stat_issued,
   output logic [$clog2(TAG_DEPTH):0] stat_max_inflight,
`endif
   output logic                  busy
);

   localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [TW:0] NR = (TW+1)'(N_REQ);
   localparam logic [CW-1:0] DEPTH = CW'(TAG_DEPTH);

   logic          a_pend_q, a_pend_d;
   logic          b_pend_q, b_pend_d;
   logic [31:0]   a_data_q, a_data_d;
   logic [31:0]   b_data_q, b_data_d;
   logic [TW-1:0] rr_q, rr_d;
   logic [TW-1:0] tag_q [TAG_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic               a_hs, b_hs, r_hs;
   logic               stage_free, fifo_full, fifo_empty;
   logic               found, gnt;
   logic [2*N_REQ-1:0] dbl_req, rot_req;
   logic [TW-1:0]      off, gnt_idx, head_tag;
   logic [TW:0]        sum, nxt;
   logic [31:0]        a_sel, b_sel;
   logic [N_REQ-1:0]   head_oh;

   assign a_hs       = a_pend_q & mul_a_tready;
   assign b_hs       = b_pend_q & mul_b_tready;
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == DEPTH);
   // A and B retire independently; the stage frees once neither is left pending.
   assign stage_free = (!a_pend_q | a_hs) & (!b_pend_q | b_hs);

   always_comb begin
      dbl_req = {req_valid, req_valid};
      rot_req = dbl_req >> rr_q;
      off     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_req[k]) off = TW'(k);
      end
      found = |req_valid;
      sum   = {1'b0, rr_q} + {1'b0, off};
      if (sum >= NR) gnt_idx = TW'(sum - NR);
      else           gnt_idx = sum[TW-1:0];
      gnt = found & stage_free & !fifo_full & !rst;
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == TW'(i)) begin
            a_sel = req_a_tdata[32*i +: 32];
            b_sel = req_b_tdata[32*i +: 32];
         end
      end
   end

   assign req_ready = gnt ? (N_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      a_pend_d = a_pend_q;
      b_pend_d = b_pend_q;
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      rr_d     = rr_q;
      nxt      = {1'b0, gnt_idx} + 1'b1;
      if (a_hs) a_pend_d = 1'b0;
      if (b_hs) b_pend_d = 1'b0;
      if (gnt) begin
         a_pend_d = 1'b1;
         b_pend_d = 1'b1;
         a_data_d = a_sel;
         b_data_d = b_sel;
         rr_d     = (nxt == NR) ? '0 : nxt[TW-1:0];
      end
   end

   assign mul_a_tvalid = a_pend_q;
   assign mul_b_tvalid = b_pend_q;
   assign mul_a_tdata  = a_data_q;
   assign mul_b_tdata  = b_data_q;

   // Results come back in issue order, so the FIFO head names the owner.
   assign head_tag     = tag_q[rd_ptr_q];
   assign head_oh      = N_REQ'(1) << head_tag;
   assign mul_r_tready = !fifo_empty & |(rsp_ready & head_oh);
   assign rsp_valid    = (mul_r_tvalid & !fifo_empty) ? head_oh : '0;
   assign rsp_tdata    = mul_r_tdata;
   assign r_hs         = mul_r_tvalid & mul_r_tready;

   always_comb begin
      wr_ptr_d = gnt  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = r_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + CW'(gnt) - CW'(r_hs);
   end

   assign busy = a_pend_q | b_pend_q | !fifo_empty;

   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         a_pend_q <= 1'b0;
         b_pend_q <= 1'b0;
         a_data_q <= '0;
         b_data_q <= '0;
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         a_pend_q <= a_pend_d;
         b_pend_q <= b_pend_d;
         a_data_q <= a_data_d;
         b_data_q <= b_data_d;
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
      end else if (gnt) begin
         tag_q[wr_ptr_q] <= gnt_idx;
      end
   end

`ifdef FPMUL_ARB_STATS_EN
   logic [31:0]   iss_q [N_REQ];
   logic [CW-1:0] hwm_q;

   always_ff @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) iss_q[i] <= '0;
         hwm_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt && gnt_idx == TW'(i)) iss_q[i] <= iss_q[i] + 32'd1;
         end
         if (cnt_d > hwm_q) hwm_q <= cnt_d;
      end
   end

   always_comb begin
      stat_issued = '0;
      for (int i = 0; i < N_REQ; i++) stat_issued[32*i +: 32] = iss_q[i];
   end

   assign stat_max_inflight = hwm_q;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed scoreboard bench for fp_mul_arbiter with a behavioural
// fixed-latency multiplier standing in for floating_point_mul_1.
module tb_fp_mul_arbiter;

   localparam int N   = 2;
   localparam int TD  = 32;
   localparam int LAT = 3;

   logic            bus_clk;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready;
   logic [32*N-1:0] req_a_tdata, req_b_tdata;
   logic [N-1:0]    rsp_valid, rsp_ready;
   logic [31:0]     rsp_tdata;
   logic            mul_a_tvalid, mul_a_tready;
   logic [31:0]     mul_a_tdata;
   logic            mul_b_tvalid, mul_b_tready;
   logic [31:0]     mul_b_tdata;
   logic            mul_r_tvalid, mul_r_tready;
   logic [31:0]     mul_r_tdata;
   logic            busy;
`ifdef FPMUL_ARB_STATS_EN
   logic [32*N-1:0] stat_issued;
   logic [5:0]      stat_max_inflight;
`endif

   fp_mul_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
      .bus_clk      (bus_clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a_tdata  (req_a_tdata),
      .req_b_tdata  (req_b_tdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_tdata    (rsp_tdata),
      .mul_a_tvalid (mul_a_tvalid),
      .mul_a_tready (mul_a_tready),
      .mul_a_tdata  (mul_a_tdata),
      .mul_b_tvalid (mul_b_tvalid),
      .mul_b_tready (mul_b_tready),
      .mul_b_tdata  (mul_b_tdata),
      .mul_r_tvalid (mul_r_tvalid),
      .mul_r_tready (mul_r_tready),
      .mul_r_tdata  (mul_r_tdata),
`ifdef FPMUL_ARB_STATS_EN
      .stat_issued       (stat_issued),
      .stat_max_inflight (stat_max_inflight),
`endif
      .busy         (busy)
   );

   initial bus_clk = 1'b0;
   always #5 bus_clk = ~bus_clk;

   // Known IEEE products for the directed pairs; other pairs use a^b so
   // every result is distinguishable and ordering errors show up.
   function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (a == 32'h3F99999A && b == 32'h3F99999A) return 32'h3FB851EC;
      return a ^ b;
   endfunction

   logic [31:0] ma_q[$];
   logic [31:0] mb_q[$];
   logic [31:0] pd_q[$];
   int          pt_q[$];
   int          cyc;

   always @(posedge bus_clk or posedge rst) begin
      if (rst) begin
         ma_q.delete();
         mb_q.delete();
         pd_q.delete();
         pt_q.delete();
         cyc = 0;
         mul_r_tvalid <= 1'b0;
         mul_r_tdata  <= '0;
      end else begin
         cyc++;
         if (mul_r_tvalid && mul_r_tready) begin
            void'(pd_q.pop_front());
            void'(pt_q.pop_front());
         end
         if (mul_a_tvalid && mul_a_tready) ma_q.push_back(mul_a_tdata);
         if (mul_b_tvalid && mul_b_tready) mb_q.push_back(mul_b_tdata);
         if (ma_q.size() > 0 && mb_q.size() > 0) begin
            pd_q.push_back(mul_ref(ma_q.pop_front(), mb_q.pop_front()));
            pt_q.push_back(cyc + LAT);
         end
         if (pd_q.size() > 0 && pt_q[0] <= cyc) begin
            mul_r_tvalid <= 1'b1;
            mul_r_tdata  <= pd_q[0];
         end else begin
            mul_r_tvalid <= 1'b0;
         end
      end
   end

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_gnt    = 0;
   int          gcnt [N];
   int          exp_rr   = 0;
   int          peak     = 0;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   int          ord_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [N-1:0] eoh;
      logic [31:0]  e;
      int           gi;
      #1;
      if (req_ready != '0) begin
         eoh = '0;
         for (int k = 0; k < N; k++) begin
            gi = (exp_rr + k) % N;
            if (eoh == '0 && req_valid[gi]) eoh[gi] = 1'b1;
         end
         chk("grant_onehot", 32'(req_ready), 32'(eoh));
      end
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            e = mul_ref(req_a_tdata[32*i +: 32], req_b_tdata[32*i +: 32]);
            if (i == 0) exp0.push_back(e);
            else        exp1.push_back(e);
            ord_q.push_back(i);
            n_gnt++;
            gcnt[i]++;
            exp_rr = (i + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i] && rsp_ready[i]) begin
            if (ord_q.size() == 0) begin
               chk("rsp_unexpected", 32'(ord_q.size()), 32'd1);
            end else begin
               chk("rsp_port", 32'(i), 32'(ord_q.pop_front()));
               if (i == 0) e = (exp0.size() > 0) ? exp0.pop_front() : 32'hxxxxxxxx;
               else        e = (exp1.size() > 0) ? exp1.pop_front() : 32'hxxxxxxxx;
               chk("rsp_data", rsp_tdata, e);
               chk("rsp_r_tready", 32'(mul_r_tready), 32'd1);
            end
         end
      end
      if (ord_q.size() > peak) peak = ord_q.size();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      while (ord_q.size() > 0 && t < 400) begin
         cycle();
         t++;
      end
      chk("drain_left", 32'(ord_q.size()), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int n0, t;
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      rst          = 1'b1;
      req_valid    = '1;
      req_a_tdata  = '0;
      req_b_tdata  = '0;
      rsp_ready    = '1;
      mul_a_tready = 1'b1;
      mul_b_tready = 1'b1;
      cycle();
      cycle();
      chk("reset_outs", {25'd0, req_ready, rsp_valid, mul_a_tvalid,
                         mul_b_tvalid, mul_r_tready}, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst       = 1'b0;
      req_valid = '0;
      cycle();

      // single product, one-cycle issue latency
      req_a_tdata[31:0] = 32'h40000000;
      req_b_tdata[31:0] = 32'h40400000;
      req_valid = 2'b01;
      #1;
      chk("single_ready", 32'(req_ready), 32'd1);
      cycle();
      req_valid = '0;
      chk("single_a_valid", 32'(mul_a_tvalid), 32'd1);
      chk("single_b_valid", 32'(mul_b_tvalid), 32'd1);
      chk("single_a_data", mul_a_tdata, 32'h40000000);
      chk("single_b_data", mul_b_tdata, 32'h40400000);
      drain();

      // two requesters contending
      req_a_tdata = {2{32'h3F99999A}};
      req_b_tdata = {2{32'h3F99999A}};
      n0 = gcnt[0];
      t  = gcnt[1];
      req_valid = 2'b11;
      for (int k = 0; k < 8; k++) cycle();
      req_valid = '0;
      chk("rr_cnt0", 32'(gcnt[0] - n0), 32'd4);
      chk("rr_cnt1", 32'(gcnt[1] - t), 32'd4);
      drain();

      // B channel stall after A accepted
      req_a_tdata[31:0] = 32'h11111111;
      req_b_tdata[31:0] = 32'h22222222;
      mul_b_tready = 1'b0;
      n0 = n_gnt;
      req_valid = 2'b01;
      cycle();
      cycle();
      for (int k = 0; k < 3; k++) begin
         chk("stall_a_valid", 32'(mul_a_tvalid), 32'd0);
         chk("stall_b_valid", 32'(mul_b_tvalid), 32'd1);
         chk("stall_b_data", mul_b_tdata, 32'h22222222);
         chk("stall_no_grant", 32'(req_ready), 32'd0);
         cycle();
      end
      mul_b_tready = 1'b1;
      #1;
      chk("stall_release_grant", 32'(req_ready), 32'd1);
      cycle();
      req_valid = '0;
      chk("stall_grants", 32'(n_gnt - n0), 32'd2);
      drain();

      // requester 0 backpressured until the tag FIFO fills
      rsp_ready = 2'b10;
      req_b_tdata[31:0] = 32'h5A5A0000;
      n0 = n_gnt;
      req_valid = 2'b01;
      for (int k = 0; k < 40; k++) begin
         req_a_tdata[31:0] = 32'h1000 + 32'(n_gnt);
         cycle();
      end
      chk("full_grants", 32'(n_gnt - n0), 32'(TD));
      chk("full_no_ready", 32'(req_ready), 32'd0);
      chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("full_r_tready", 32'(mul_r_tready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      req_valid = '0;
      rsp_ready = '1;
      drain();
`ifdef FPMUL_ARB_STATS_EN
      chk("stat_iss0", stat_issued[31:0], 32'(gcnt[0]));
      chk("stat_iss1", stat_issued[63:32], 32'(gcnt[1]));
      chk("stat_peak", 32'(stat_max_inflight), 32'(peak));
`endif

      // reset with products in flight
      rsp_ready = '0;
      n0 = n_gnt;
      t  = 0;
      req_valid = 2'b11;
      while (n_gnt - n0 < 5 && t < 20) begin
         cycle();
         t++;
      end
      chk("inflight_grants", 32'(n_gnt - n0), 32'd5);
      rst = 1'b1;
      #1;
      chk("midrst_outs", {25'd0, req_ready, rsp_valid, mul_a_tvalid,
                          mul_b_tvalid, mul_r_tready}, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      exp0.delete();
      exp1.delete();
      ord_q.delete();
      exp_rr = 0;
      peak   = 0;
      for (int i = 0; i < N; i++) gcnt[i] = 0;
      cycle();
      cycle();
      rst = 1'b0;
      rsp_ready = '1;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'd1);
      cycle();
      req_valid = '0;
      drain();
`ifdef FPMUL_ARB_STATS_EN
      chk("stat_iss0_rst", stat_issued[31:0], 32'(gcnt[0]));
      chk("stat_iss1_rst", stat_issued[63:32], 32'(gcnt[1]));
      chk("stat_peak_rst", 32'(stat_max_inflight), 32'(peak));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
